// File: rtl/count_sched_if.sv
// Request/counter bundle between the two-requester countdown scheduler and its environment.
// The master side drives requests, lengths and the external counter value; the slave side is the scheduler.
interface count_sched_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       req;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;

  modport master (
    output req, len0, len1, cnt_q,
    input  cnt_load, cnt_load_val, cnt_en, gnt, done, busy
  );

  modport slave (
    input  req, len0, len1, cnt_q,
    output cnt_load, cnt_load_val, cnt_en, gnt, done, busy
  );
endinterface

// File: rtl/count_sched_ctrl.sv
// Round-robin scheduler that grants one of two requesters a shared external down counter,
// loads it with the winner's length, counts it to zero and pulses done for the winner.
module count_sched_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  count_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic             win, win_nxt;
  logic [CNT_W-1:0] len_lat, len_nxt;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;

  function automatic logic [1:0] sel_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= 1'b0;
      win     <= 1'b0;
      len_lat <= '0;
    end else begin
      state   <= state_nxt;
      prio    <= prio_nxt;
      win     <= win_nxt;
      len_lat <= len_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    prio_nxt     = prio;
    win_nxt      = win;
    len_nxt      = len_lat;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    gnt          = 2'b00;
    done         = 2'b00;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // Contention goes to the pointer; a lone request wins outright.
          win_nxt   = (bus.req == 2'b11) ? prio : bus.req[1];
          len_nxt   = win_nxt ? bus.len1 : bus.len0;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        gnt          = sel_onehot(win);
        cnt_load_val = len_lat;
        if (!bus.req[win]) begin
          state_nxt = IDLE;
          prio_nxt  = ~win;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        gnt = sel_onehot(win);
        if (!bus.req[win]) begin
          state_nxt = IDLE;
          prio_nxt  = ~win;
        end else if (bus.cnt_q == '0) begin
          // Enable stays low on the zero cycle so the counter never underflows.
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        gnt       = sel_onehot(win);
        done      = sel_onehot(win);
        state_nxt = IDLE;
        prio_nxt  = ~win;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cnt_load     = cnt_load;
  assign bus.cnt_load_val = cnt_load_val;
  assign bus.cnt_en       = cnt_en;
  assign bus.gnt          = gnt;
  assign bus.done         = done;
  assign bus.busy         = busy;

endmodule

// File: tb/tb_count_sched_ctrl.sv
// Scoreboard bench for count_sched_ctrl: stimulus queues expected load/done events,
// a negedge monitor pops and compares them and checks per-cycle output invariants.
module tb_count_sched_ctrl;
  localparam int CNT_W = 4;
  localparam int WAIT_MAX = 100;

  typedef struct {
    bit         is_done;
    logic [1:0] gnt;
    int         val;
    int         delta;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  count_sched_if #(.CNT_W(CNT_W)) bus ();
  count_sched_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Model of the external down counter: load wins over enable.
  logic [CNT_W-1:0] cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (bus.cnt_load) cnt <= bus.cnt_load_val;
    else if (bus.cnt_en)   cnt <= cnt - 1'b1;
  end
  assign bus.cnt_q = cnt;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  tmo_cnt = 0;
  int  tmo_seen = 0;
  bit  fin = 1'b0;

  // Monitor state
  int         cyc = 0;
  int         prev_cyc = 0;
  int         en_cnt = 0;
  int         ev_no = 0;
  logic [1:0] last_gnt = 2'b00;
  ev_t        e;
  bit         act_done;
  logic [1:0] act_gnt;
  int         act_val;
  int         act_delta;
  bit         inv_ok;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      n_cmp++;
      if ({bus.gnt, bus.done, bus.busy, bus.cnt_load, bus.cnt_en, bus.cnt_load_val} != '0) begin
        n_bad++;
        $display("FAIL reset_outputs: got gnt=%b done=%b busy=%b load=%b en=%b val=%0d, required all 0",
                 bus.gnt, bus.done, bus.busy, bus.cnt_load, bus.cnt_en, bus.cnt_load_val);
      end
    end else begin
      if (bus.cnt_load || bus.done != 2'b00) begin
        ev_no++;
        n_cmp++;
        act_done  = (bus.done != 2'b00);
        act_gnt   = bus.cnt_load ? bus.gnt : bus.done;
        act_val   = bus.cnt_load ? int'(bus.cnt_load_val) : en_cnt;
        act_delta = cyc - prev_cyc;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event#%0d: got done=%0b gnt=%b val=%0d, required no event",
                   ev_no, act_done, act_gnt, act_val);
        end else begin
          e = exp_q.pop_front();
          if (act_done != e.is_done || act_gnt != e.gnt || act_val != e.val ||
              (e.delta >= 0 && act_delta != e.delta) || (act_done && cnt != '0)) begin
            n_bad++;
            $display("FAIL event#%0d: got done=%0b gnt=%b val=%0d dcyc=%0d cnt=%0d, required done=%0b gnt=%b val=%0d dcyc=%0d cnt=0",
                     ev_no, act_done, act_gnt, act_val, act_delta, cnt, e.is_done, e.gnt, e.val, e.delta);
          end
        end
        prev_cyc = cyc;
        if (bus.cnt_load) begin
          en_cnt   = 0;
          last_gnt = bus.gnt;
        end
      end
      if (bus.cnt_en) en_cnt++;
      n_cmp++;
      inv_ok = !(bus.cnt_load && bus.cnt_en) && $onehot0(bus.gnt) && $onehot0(bus.done) &&
               (bus.busy ? (bus.gnt == last_gnt) : (bus.gnt == 2'b00)) &&
               !(bus.cnt_en && cnt == '0);
      if (!inv_ok) begin
        n_bad++;
        $display("FAIL invariant@%0d: got gnt=%b done=%b busy=%b load=%b en=%b cnt=%0d, required exclusive load/en, one-hot gnt=%b while busy, no underflow",
                 cyc, bus.gnt, bus.done, bus.busy, bus.cnt_load, bus.cnt_en, cnt, last_gnt);
      end
    end
    if (tmo_cnt != tmo_seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_bound: got %0d expired waits, required 0", tmo_cnt - tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (fin) begin
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL pending_events: got %0d left in queue, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic push(input bit d, input logic [1:0] g, input int v, input int dl);
    ev_t x;
    x.is_done = d;
    x.gnt     = g;
    x.val     = v;
    x.delta   = dl;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1);
    @(negedge clk);
    bus.req  = r;
    bus.len0 = l0;
    bus.len1 = l1;
  endtask

  task automatic wait_load();
    bit seen = 1'b0;
    for (int i = 0; i < WAIT_MAX && !seen; i++) begin
      @(negedge clk);
      if (bus.cnt_load) seen = 1'b1;
    end
    if (!seen) tmo_cnt++;
  endtask

  task automatic wait_done(input logic [1:0] clr);
    bit seen = 1'b0;
    for (int i = 0; i < WAIT_MAX && !seen; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        seen    = 1'b1;
        bus.req = bus.req & ~clr;
      end
    end
    if (!seen) tmo_cnt++;
  endtask

  task automatic rst_assert();
    @(posedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.len0 = '0;
    bus.len1 = '0;
    rst_assert();
    rst_release();

    // Single request len0=3; len0 changed right after the grant edge must be ignored.
    push(1'b0, 2'b01, 3, -1);
    push(1'b1, 2'b01, 3, 5);
    issue(2'b01, 4'd3, 4'd0);
    @(posedge clk);
    #1 bus.len0 = 4'd9;
    wait_done(2'b11);

    // Both requesting from reset: 0, then 1, then 0 again.
    rst_assert();
    rst_release();
    push(1'b0, 2'b01, 2, -1);
    push(1'b1, 2'b01, 2, 4);
    push(1'b0, 2'b10, 5, 2);
    push(1'b1, 2'b10, 5, 7);
    push(1'b0, 2'b01, 2, 2);
    push(1'b1, 2'b01, 2, 4);
    issue(2'b11, 4'd2, 4'd5);
    wait_done(2'b00);
    wait_done(2'b00);
    wait_done(2'b11);

    // Zero length on requester 1.
    push(1'b0, 2'b10, 0, -1);
    push(1'b1, 2'b10, 0, 2);
    issue(2'b10, 4'd0, 4'd0);
    wait_done(2'b11);

    // Full-range length on requester 0.
    push(1'b0, 2'b01, 15, -1);
    push(1'b1, 2'b01, 15, 17);
    issue(2'b01, 4'd15, 4'd0);
    wait_done(2'b11);

    // Abort of requester 0 in its 2nd COUNT cycle; held-off requester 1 then served.
    push(1'b0, 2'b01, 6, -1);
    push(1'b0, 2'b10, 1, 4);
    push(1'b1, 2'b10, 1, 3);
    issue(2'b01, 4'd6, 4'd1);
    wait_load();
    bus.req = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1 bus.req = 2'b10;
    wait_done(2'b11);

    // Asynchronous reset mid-COUNT, then a clean reload of the current len0.
    push(1'b0, 2'b01, 8, -1);
    issue(2'b01, 4'd8, 4'd0);
    wait_load();
    repeat (2) @(negedge clk);
    rst_assert();
    bus.len0 = 4'd4;
    push(1'b0, 2'b01, 4, -1);
    push(1'b1, 2'b01, 4, 6);
    rst_release();
    wait_done(2'b11);

    repeat (2) @(negedge clk);
    fin = 1'b1;
    repeat (3) @(negedge clk);
    $display("FAIL monitor_end: summary not reached, required summary");
    $fatal(1);
  end
endmodule
